// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-maskable multiport memory.
package memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    // Widest word the merge helper handles; callers cast to and from their own width.
    localparam int MAX_BYTES = 32;
    localparam int MAX_WIDTH = MAX_BYTES * 8;

    function automatic logic [MAX_WIDTH-1:0] byteMerge(
        input logic [MAX_WIDTH-1:0] oldWord,
        input logic [MAX_WIDTH-1:0] newWord,
        input logic [MAX_BYTES-1:0] mask
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = oldWord;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = newWord[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/memory_read_port.sv
// One read port: range check, write-first forwarding and optional output register.
module memory_read_port
    import memory_pkg::*;
#(
    parameter int MEM_WIDTH_BYTES = 4,
    parameter int MEM_DEPTH       = 16,
    parameter int SHOWAHEAD       = 0,
    parameter int WRITE_FIRST     = 1,
    localparam int W  = MEM_WIDTH_BYTES * 8,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready_in,
    input  logic                       read_in,
    input  logic [AW-1:0]              read_addr_in,
    input  logic                       write_en_in,
    input  logic [AW-1:0]              write_addr_in,
    input  logic [MEM_WIDTH_BYTES-1:0] write_mask_in,
    input  logic [W-1:0]               data_in,
    input  logic [W-1:0]               mem_in [MEM_DEPTH],
    output logic [W-1:0]               lookup_out,
    output logic [W-1:0]               data_out,
    output logic                       valid_out
);

    logic         w_inRange;
    logic         w_forward;
    logic         w_accept;
    logic [W-1:0] w_stored;
    logic [W-1:0] w_readData;

    // Out-of-range addresses read as zero; write_en_in only ever flags in-range writes.
    always_comb begin
        w_inRange  = 32'(read_addr_in) < MEM_DEPTH;
        w_stored   = w_inRange ? mem_in[read_addr_in] : '0;
        w_forward  = (WRITE_FIRST != 0) && write_en_in && (read_addr_in == write_addr_in);
        w_readData = w_forward
                   ? W'(byteMerge(MAX_WIDTH'(w_stored), MAX_WIDTH'(data_in), MAX_BYTES'(write_mask_in)))
                   : w_stored;
        w_accept   = read_in && ready_in;
    end

    assign lookup_out = w_readData;

    // Some configurations leave these inputs without a reader.
    logic w_unusedInputs;
    assign w_unusedInputs = ^{clk, reset, write_mask_in, data_in};

    if (SHOWAHEAD != 0) begin : g_comb
        assign data_out  = w_readData;
        assign valid_out = w_accept;
    end else begin : g_reg
        logic [W-1:0] r_data;
        logic         r_valid;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_accept;
                if (w_accept) begin
                    r_data <= w_readData;
                end
            end
        end

        assign data_out  = r_data;
        assign valid_out = r_valid;
    end

endmodule

// File: rtl/multiport_memory.sv
// Byte-maskable RAM with several independent read ports and an optional post-reset clear.
module multiport_memory
    import memory_pkg::*;
#(
    parameter int MEM_WIDTH_BYTES = 4,
    parameter int MEM_DEPTH       = 16,
    parameter int READ_PORTS      = 2,
    parameter int SHOWAHEAD       = 0,
    parameter int WRITE_FIRST     = 1,
    parameter int CLEAR_ON_RESET  = 1,
    localparam int W  = MEM_WIDTH_BYTES * 8,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [AW-1:0]                  write_addr_in,
    input  logic                           write_in,
    input  logic [MEM_WIDTH_BYTES-1:0]     write_mask_in,
    input  logic [W-1:0]                   data_in,
    input  logic [READ_PORTS-1:0][AW-1:0]  read_addr_in,
    input  logic [READ_PORTS-1:0]          read_in,
    output logic [READ_PORTS-1:0][W-1:0]   data_out,
    output logic [READ_PORTS-1:0]          valid_out,
    output logic                           ready_out,
    input  logic                           debugen_in
);

    logic [W-1:0]                 r_mem [MEM_DEPTH];
    mem_state_e                   r_state;
    mem_state_e                   w_nextState;
    logic [AW-1:0]                r_clearAddr;
    logic                         w_ready;
    logic                         w_writeEn;
    logic [READ_PORTS-1:0][W-1:0] w_lookup;

    assign w_ready   = (r_state == READY);
    assign ready_out = w_ready;
    assign w_writeEn = write_in && w_ready && !reset && (32'(write_addr_in) < MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_clearAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == CLEAR) begin
                r_clearAddr <= r_clearAddr + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == CLEAR && r_clearAddr == AW'(MEM_DEPTH - 1)) begin
            w_nextState = READY;
        end
    end

    // Storage has no reset of its own; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            if (!reset) begin
                r_mem[r_clearAddr] <= '0;
            end
        end else if (w_writeEn) begin
            r_mem[write_addr_in] <= W'(byteMerge(MAX_WIDTH'(r_mem[write_addr_in]),
                                                 MAX_WIDTH'(data_in),
                                                 MAX_BYTES'(write_mask_in)));
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_readPort
        memory_read_port #(
            .MEM_WIDTH_BYTES (MEM_WIDTH_BYTES),
            .MEM_DEPTH       (MEM_DEPTH),
            .SHOWAHEAD       (SHOWAHEAD),
            .WRITE_FIRST     (WRITE_FIRST)
        ) u_readPort (
            .clk           (clk),
            .reset         (reset),
            .ready_in      (w_ready),
            .read_in       (read_in[p]),
            .read_addr_in  (read_addr_in[p]),
            .write_en_in   (w_writeEn),
            .write_addr_in (write_addr_in),
            .write_mask_in (write_mask_in),
            .data_in       (data_in),
            .mem_in        (r_mem),
            .lookup_out    (w_lookup[p]),
            .data_out      (data_out[p]),
            .valid_out     (valid_out[p])
        );
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (debugen_in && !reset && w_ready) begin
            $write("%m:");
            if (write_in) begin
                $write(" write (%b)%h@%h", write_mask_in, data_in, write_addr_in);
            end
            for (int p = 0; p < READ_PORTS; p++) begin
                if (read_in[p]) begin
                    $write(" (read)%h@%h", w_lookup[p], read_addr_in[p]);
                end
            end
            $write("\n");
        end
    end
`endif

endmodule
